display_bin_bcd: RTL and testbench

- Sequential multi-digit display driver for the RPN ALU result path.
- Accepts a WIDTH-bit binary value on a start strobe and converts it to DIGITS 7-segment glyphs, active-low.
- Decimal mode uses iterative double-dabble, one bit per cycle, and supports signed input with a separate minus-sign segment.
- Hex mode is a direct nibble decode.
- Supersedes the single-digit fixed-width BCD decoder at the board display outputs.

---
 rtl/display_pkg.sv | 30 +++
 rtl/seg7_glyph.sv | 32 +++
 rtl/display_bin_bcd.sv | 163 ++++++++++++++++
 tb/tb_display_bin_bcd.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the multi-digit 7-segment display driver.
// Glyphs are active-low, bit order g..a.
package display_pkg;

  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_B     = 7'b0000011;
  localparam logic [6:0] GLYPH_C     = 7'b1000110;
  localparam logic [6:0] GLYPH_D     = 7'b0100001;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_F     = 7'b0001110;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  // Converter FSM states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SHIFT  = 2'd1;
  localparam state_t ST_FINISH = 2'd2;

endpackage

// File: rtl/seg7_glyph.sv
// Combinational 4-bit to active-low 7-segment glyph decoder (hex digits 0..F).
module seg7_glyph
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  // Map each nibble value to its glyph
  always_comb begin
    glyph = GLYPH_BLANK;
    unique case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/display_bin_bcd.sv
// Sequential multi-digit display driver: binary value to DIGITS active-low
// 7-segment glyphs, decimal (iterative double-dabble, optional sign) or hex.
// Build option: define DISPLAY_LZB_EN for leading-zero blanking.
module display_bin_bcd
  import display_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  input  logic                  is_signed,
  input  logic                  hex_mode,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   seg,
  output logic [6:0]            sign_seg
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned XW = (WIDTH > BW) ? WIDTH : BW;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [BW-1:0]       bcd_q;
  logic [WIDTH-1:0]    mag_q;
  logic                ovf_q;
  logic                neg_q;
  logic [7*DIGITS-1:0] seg_q, seg_d;
  logic [6:0]          sign_q, sign_d;
  logic                overflow_q;

  logic                accept;
  logic                in_neg;
  logic [WIDTH-1:0]    in_mag;
  logic [XW-1:0]       value_ext;
  logic [BW-1:0]       hex_src;
  logic                hex_ovf;
  logic [BW-1:0]       bcd_adj;
  logic [BW-1:0]       bcd_shift;
  logic [WIDTH-1:0]    mag_shift;
  logic                carry;
  logic                last_shift;
  logic                load_out;
  logic [BW-1:0]       fin_nib;
  logic                fin_ovf;
  logic                fin_neg;
  logic [7*DIGITS-1:0] glyph_raw;

  // Input capture: sign handling and hex zero-extension
  always_comb begin
    accept    = (state_q == ST_IDLE) && start;
    in_neg    = is_signed && value[WIDTH-1];
    // Magnitude fits WIDTH unsigned bits, so the most negative value is exact
    in_mag    = in_neg ? (~value + WIDTH'(1)) : value;
    value_ext = XW'(value);
    hex_src   = value_ext[BW-1:0];
    hex_ovf   = |(value_ext >> BW);
  end

  // Double-dabble step: +3 on nibbles >= 5, then shift {bcd, mag} left
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    carry     = bcd_adj[BW-1];
    bcd_shift = {bcd_adj[BW-2:0], mag_q[WIDTH-1]};
    mag_shift = {mag_q[WIDTH-2:0], 1'b0};
  end

  // Result source: hex path from the input, decimal path from the final shift
  always_comb begin
    last_shift = (state_q == ST_SHIFT) && (cnt_q == CW'(1));
    load_out   = (accept && hex_mode) || last_shift;
    fin_nib    = (state_q == ST_SHIFT) ? bcd_shift : hex_src;
    fin_ovf    = (state_q == ST_SHIFT) ? (ovf_q | carry) : hex_ovf;
    fin_neg    = (state_q == ST_SHIFT) ? neg_q : 1'b0;
  end

  for (genvar k = 0; k < int'(DIGITS); k++) begin : g_digit
    seg7_glyph u_glyph (
      .nibble (fin_nib[4*k +: 4]),
      .glyph  (glyph_raw[7*k +: 7])
    );
  end

  // Final glyphs with overflow dashes and optional leading-zero blanking
  always_comb begin
`ifdef DISPLAY_LZB_EN
    logic seen;
    seen = 1'b0;
`endif
    seg_d = glyph_raw;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      if (fin_ovf) begin
        seg_d[7*k +: 7] = GLYPH_DASH;
      end
`ifdef DISPLAY_LZB_EN
      if (fin_nib[4*k +: 4] != 4'd0) seen = 1'b1;
      if (!fin_ovf && !seen && (k != 0)) seg_d[7*k +: 7] = GLYPH_BLANK;
`endif
    end
    sign_d = fin_neg ? GLYPH_DASH : GLYPH_BLANK;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = hex_mode ? ST_FINISH : ST_SHIFT;
      ST_SHIFT:  if (last_shift) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bcd_q      <= '0;
      mag_q      <= '0;
      ovf_q      <= 1'b0;
      neg_q      <= 1'b0;
      seg_q      <= {(7*DIGITS){1'b1}};
      sign_q     <= GLYPH_BLANK;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && !hex_mode) begin
        mag_q <= in_mag;
        bcd_q <= '0;
        cnt_q <= CW'(WIDTH);
        ovf_q <= 1'b0;
        neg_q <= in_neg;
      end else if (state_q == ST_SHIFT) begin
        bcd_q <= bcd_shift;
        mag_q <= mag_shift;
        cnt_q <= cnt_q - CW'(1);
        ovf_q <= ovf_q | carry;
      end
      // Outputs land on the edge entering FINISH so they are valid with done
      if (load_out) begin
        seg_q      <= seg_d;
        sign_q     <= sign_d;
        overflow_q <= fin_ovf;
      end
    end
  end

  assign busy     = (state_q == ST_SHIFT);
  assign done     = (state_q == ST_FINISH);
  assign overflow = overflow_q;
  assign seg      = seg_q;
  assign sign_seg = sign_q;

endmodule

// File: tb/tb_display_bin_bcd.sv
// Scoreboard bench for display_bin_bcd: three instances (3, 2 and 1 digits).
module tb_display_bin_bcd;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0010000;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GC = 7'b1000110;
  localparam logic [6:0] GF = 7'b0001110;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;
`ifdef DISPLAY_LZB_EN
  localparam logic [6:0] LZ = BLANK;
`else
  localparam logic [6:0] LZ = G0;
`endif

  typedef struct packed {
    logic [20:0] seg;
    logic [6:0]  sgn;
    logic        ovf;
    logic [31:0] at;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, is_signed, hex_mode;
  logic [7:0] value;
  logic       start0, start1, start2;
  logic       busy0, done0, ovf0, busy1, done1, ovf1, busy2, done2, ovf2;
  logic [20:0] seg0;
  logic [13:0] seg1;
  logic [6:0]  seg2;
  logic [6:0]  sign0, sign1, sign2;

  int unsigned cyc = 0;
  int errors = 0;
  int checks = 0;
  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2, ex;
  logic sb;

  always @(posedge clk) cyc <= cyc + 1;

  display_bin_bcd #(.WIDTH(8), .DIGITS(3)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .value(value), .is_signed(is_signed),
    .hex_mode(hex_mode), .busy(busy0), .done(done0), .overflow(ovf0), .seg(seg0),
    .sign_seg(sign0)
  );
  display_bin_bcd #(.WIDTH(8), .DIGITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .value(value), .is_signed(is_signed),
    .hex_mode(hex_mode), .busy(busy1), .done(done1), .overflow(ovf1), .seg(seg1),
    .sign_seg(sign1)
  );
  display_bin_bcd #(.WIDTH(8), .DIGITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .value(value), .is_signed(is_signed),
    .hex_mode(hex_mode), .busy(busy2), .done(done2), .overflow(ovf2), .seg(seg2),
    .sign_seg(sign2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitors: pop and compare whenever an instance pulses done
  always @(negedge clk) begin
    if (!rst && done0) begin
      if (q0.size() == 0) check("dut0 unexpected done", 32'd1, 32'd0);
      else begin
        e0 = q0.pop_front();
        check("dut0 seg", seg0, e0.seg);
        check("dut0 sign", sign0, e0.sgn);
        check("dut0 overflow", ovf0, e0.ovf);
        check("dut0 done cycle", cyc, e0.at);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done1) begin
      if (q1.size() == 0) check("dut1 unexpected done", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        check("dut1 seg", seg1, e1.seg[13:0]);
        check("dut1 sign", sign1, e1.sgn);
        check("dut1 overflow", ovf1, e1.ovf);
        check("dut1 done cycle", cyc, e1.at);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done2) begin
      if (q2.size() == 0) check("dut2 unexpected done", 32'd1, 32'd0);
      else begin
        e2 = q2.pop_front();
        check("dut2 seg", seg2, e2.seg[6:0]);
        check("dut2 sign", sign2, e2.sgn);
        check("dut2 overflow", ovf2, e2.ovf);
        check("dut2 done cycle", cyc, e2.at);
      end
    end
  end

  // Issue one start to an instance, queue its expected result, and idle
  task automatic issue(input int which, input logic [7:0] v, input logic s, input logic h,
                       input logic [20:0] eseg, input logic [6:0] esgn, input logic eovf,
                       input int lat, output logic saw_busy);
    exp_t e;
    @(negedge clk);
    value = v; is_signed = s; hex_mode = h;
    e.seg = eseg; e.sgn = esgn; e.ovf = eovf; e.at = cyc + lat;
    case (which)
      0: begin start0 = 1'b1; q0.push_back(e); end
      1: begin start1 = 1'b1; q1.push_back(e); end
      default: begin start2 = 1'b1; q2.push_back(e); end
    endcase
    saw_busy = 1'b0;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      case (which)
        0: if (busy0) saw_busy = 1'b1;
        1: if (busy1) saw_busy = 1'b1;
        default: if (busy2) saw_busy = 1'b1;
      endcase
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    value = 8'd0; is_signed = 1'b0; hex_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", busy0, 0);
    check("reset done", done0, 0);
    check("reset overflow", ovf0, 0);
    check("reset seg", seg0, 21'h1FFFFF);
    check("reset sign", sign0, 7'h7F);
    rst = 1'b0;

    issue(0, 8'd255, 1'b0, 1'b0, {G2, G5, G5}, BLANK, 1'b0, 9, sb);
    check("busy seen decimal", sb, 1);
    issue(0, 8'h80, 1'b1, 1'b0, {G1, G2, G8}, DASH, 1'b0, 9, sb);
    issue(0, 8'hFF, 1'b1, 1'b0, {LZ, LZ, G1}, DASH, 1'b0, 9, sb);
    issue(0, 8'hAF, 1'b0, 1'b1, {LZ, GA, GF}, BLANK, 1'b0, 1, sb);
    check("busy never in hex", sb, 0);
    issue(0, 8'hF0, 1'b1, 1'b1, {LZ, GF, G0}, BLANK, 1'b0, 1, sb);
    issue(0, 8'h7F, 1'b1, 1'b0, {G1, G2, G7}, BLANK, 1'b0, 9, sb);
    issue(0, 8'h00, 1'b0, 1'b0, {LZ, LZ, G0}, BLANK, 1'b0, 9, sb);
    issue(1, 8'd200, 1'b0, 1'b0, {BLANK, DASH, DASH}, BLANK, 1'b1, 9, sb);
    issue(1, 8'd99, 1'b0, 1'b0, {BLANK, G9, G9}, BLANK, 1'b0, 9, sb);
    issue(1, 8'h9C, 1'b1, 1'b0, {BLANK, DASH, DASH}, DASH, 1'b1, 9, sb);
    issue(2, 8'hAF, 1'b0, 1'b1, {BLANK, BLANK, DASH}, BLANK, 1'b1, 1, sb);
    issue(2, 8'h0C, 1'b0, 1'b1, {BLANK, BLANK, GC}, BLANK, 1'b0, 1, sb);

    // Starts while busy and on the done cycle must be ignored
    @(negedge clk);
    value = 8'd100; is_signed = 1'b0; hex_mode = 1'b0; start0 = 1'b1;
    ex.seg = {G1, G0, G0}; ex.sgn = BLANK; ex.ovf = 1'b0; ex.at = cyc + 9;
    q0.push_back(ex);
    @(negedge clk); start0 = 1'b0; value = 8'h07; hex_mode = 1'b1;
    @(negedge clk);
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int i = 0; i < 20 && !done0; i++) @(negedge clk);
    if (!done0) check("wait for done", 32'd0, 32'd1);
    start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (15) @(negedge clk);

    // Reset in the middle of a conversion
    value = 8'd200; is_signed = 1'b0; hex_mode = 1'b0; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (3) @(negedge clk);
    check("busy before reset", busy0, 1);
    rst = 1'b1;
    @(negedge clk);
    check("busy after reset", busy0, 0);
    check("seg after reset", seg0, 21'h1FFFFF);
    check("sign after reset", sign0, 7'h7F);
    rst = 1'b0;
    issue(0, 8'd42, 1'b0, 1'b0, {LZ, G4, G2}, BLANK, 1'b0, 9, sb);

    repeat (5) @(negedge clk);
    check("dut0 pending results", q0.size(), 0);
    check("dut1 pending results", q1.size(), 0);
    check("dut2 pending results", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
